// File: rtl/core_types_pkg.sv
// Shared dmem-path types: block address, word, and write-buffer entry/response records.
package core_types_pkg;

  typedef logic [12:0] block_addr_t;
  typedef logic [31:0] word_t;

  localparam int WB_DEPTH       = 4;
  localparam int WB_INDEX_WIDTH = $clog2(WB_DEPTH);

  typedef struct packed {
    logic        valid;
    block_addr_t addr;
    word_t [1:0] data;
  } wb_entry_t;

  typedef struct packed {
    block_addr_t addr;
    word_t [1:0] data;
  } wb_resp_t;

endpackage

// File: rtl/wb_resp_queue.sv
// Two-entry FIFO holding locally-served read responses until the response port is free.
module wb_resp_queue
  import core_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     push,
  input  wb_resp_t push_data,
  input  logic     pop,
  output wb_resp_t pop_data,
  output logic     full,
  output logic     empty
);

  wb_resp_t   slots [2];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;

  assign empty    = (rd_ptr == wr_ptr);
  assign full     = (rd_ptr[0] == wr_ptr[0]) && (rd_ptr[1] != wr_ptr[1]);
  assign pop_data = slots[rd_ptr[0]];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      slots[0] <= '0;
      slots[1] <= '0;
    end else begin
      if (push && !full) begin
        slots[wr_ptr[0]] <= push_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Coalescing write-back buffer between dcache and the memory controller.
// Serves block reads that hit buffered data and gates the flush indication until drained.
module dmem_write_buffer
  import core_types_pkg::*;
#(
  parameter int DEPTH            = WB_DEPTH,
  parameter int SLOW_DOWN_THRESH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmem_write_req_valid,
  input  logic [12:0] dmem_write_req_block_addr,
  input  logic [63:0] dmem_write_req_data,
  output logic        dmem_write_req_blocked,
  output logic        dmem_write_req_slow_down,
  input  logic        dmem_read_req_valid,
  input  logic [12:0] dmem_read_req_block_addr,
  output logic        dmem_read_req_blocked,
  output logic        dmem_read_resp_valid,
  output logic [12:0] dmem_read_resp_block_addr,
  output logic [63:0] dmem_read_resp_data,
  output logic        mc_read_req_valid,
  output logic [12:0] mc_read_req_block_addr,
  input  logic        mc_read_resp_valid,
  input  logic [12:0] mc_read_resp_block_addr,
  input  logic [63:0] mc_read_resp_data,
  output logic        mc_write_req_valid,
  output logic [12:0] mc_write_req_block_addr,
  output logic [63:0] mc_write_req_data,
  input  logic        mc_write_req_ready,
  input  logic        dcache_flushed,
  output logic        flushed
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] SLOW_THRESH = (IW+1)'(SLOW_DOWN_THRESH);

  wb_entry_t     entries [DEPTH];
  logic [IW:0]   head;
  logic [IW:0]   tail;
  logic [IW:0]   count;
  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic          full;
  logic          empty;
  logic          drain;
  logic          wr_acc;
  logic          coalesce;
  logic [IW-1:0] coalesce_idx;

  logic          rd_acc;
  logic          rd_hit;
  logic [63:0]   rd_hit_data;

  logic          rq_push;
  logic          rq_pop;
  logic          rq_full;
  logic          rq_empty;
  logic          rq_bypass;
  wb_resp_t      rq_push_data;
  wb_resp_t      rq_head;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign count    = tail - head;
  assign full     = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign empty    = (head == tail);

  assign dmem_write_req_blocked   = full;
  assign dmem_write_req_slow_down = (count >= SLOW_THRESH);

  assign mc_write_req_valid      = entries[head_idx].valid;
  assign mc_write_req_block_addr = entries[head_idx].addr;
  assign mc_write_req_data       = entries[head_idx].data;

  assign drain  = mc_write_req_valid & mc_write_req_ready;
  assign wr_acc = dmem_write_req_valid & ~full;

  // The head leaving this cycle can't absorb new data; a same-address write becomes a fresh entry.
  always_comb begin
    coalesce     = 1'b0;
    coalesce_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr == dmem_write_req_block_addr) &&
          !(drain && (IW'(i) == head_idx))) begin
        coalesce     = 1'b1;
        coalesce_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (drain) begin
        entries[head_idx].valid <= 1'b0;
        head                    <= head + (IW+1)'(1);
      end
      if (wr_acc) begin
        if (coalesce) begin
          entries[coalesce_idx].data <= dmem_write_req_data;
        end else begin
          entries[tail_idx].valid <= 1'b1;
          entries[tail_idx].addr  <= dmem_write_req_block_addr;
          entries[tail_idx].data  <= dmem_write_req_data;
          tail                    <= tail + (IW+1)'(1);
        end
      end
    end
  end

  // Incoming write is youngest, so it overrides any buffered copy.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr == dmem_read_req_block_addr)) begin
        rd_hit      = 1'b1;
        rd_hit_data = entries[i].data;
      end
    end
    if (wr_acc && (dmem_write_req_block_addr == dmem_read_req_block_addr)) begin
      rd_hit      = 1'b1;
      rd_hit_data = dmem_write_req_data;
    end
  end

  assign dmem_read_req_blocked  = rq_full;
  assign rd_acc                 = dmem_read_req_valid & ~rq_full;
  assign mc_read_req_valid      = rd_acc & ~rd_hit;
  assign mc_read_req_block_addr = dmem_read_req_block_addr;

  // An uncontested hit with nothing queued skips the queue to keep the 1-cycle latency.
  assign rq_bypass         = rd_acc & rd_hit & rq_empty & ~mc_read_resp_valid;
  assign rq_push           = rd_acc & rd_hit & ~rq_bypass;
  assign rq_pop            = ~mc_read_resp_valid & ~rq_empty;
  assign rq_push_data.addr = dmem_read_req_block_addr;
  assign rq_push_data.data = rd_hit_data;

  wb_resp_queue u_resp_queue (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (rq_push),
    .push_data (rq_push_data),
    .pop       (rq_pop),
    .pop_data  (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dmem_read_resp_valid      <= 1'b0;
      dmem_read_resp_block_addr <= '0;
      dmem_read_resp_data       <= '0;
    end else if (mc_read_resp_valid) begin
      dmem_read_resp_valid      <= 1'b1;
      dmem_read_resp_block_addr <= mc_read_resp_block_addr;
      dmem_read_resp_data       <= mc_read_resp_data;
    end else if (rq_pop) begin
      dmem_read_resp_valid      <= 1'b1;
      dmem_read_resp_block_addr <= rq_head.addr;
      dmem_read_resp_data       <= rq_head.data;
    end else if (rq_bypass) begin
      dmem_read_resp_valid      <= 1'b1;
      dmem_read_resp_block_addr <= dmem_read_req_block_addr;
      dmem_read_resp_data       <= rd_hit_data;
    end else begin
      dmem_read_resp_valid      <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flushed <= 1'b0;
    end else if (dcache_flushed && empty && rq_empty) begin
      flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Randomized plus directed bench for dmem_write_buffer against a queue-based reference model.
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmem_write_req_valid;
  logic [12:0] dmem_write_req_block_addr;
  logic [63:0] dmem_write_req_data;
  logic        dmem_write_req_blocked;
  logic        dmem_write_req_slow_down;
  logic        dmem_read_req_valid;
  logic [12:0] dmem_read_req_block_addr;
  logic        dmem_read_req_blocked;
  logic        dmem_read_resp_valid;
  logic [12:0] dmem_read_resp_block_addr;
  logic [63:0] dmem_read_resp_data;
  logic        mc_read_req_valid;
  logic [12:0] mc_read_req_block_addr;
  logic        mc_read_resp_valid;
  logic [12:0] mc_read_resp_block_addr;
  logic [63:0] mc_read_resp_data;
  logic        mc_write_req_valid;
  logic [12:0] mc_write_req_block_addr;
  logic [63:0] mc_write_req_data;
  logic        mc_write_req_ready;
  logic        dcache_flushed;
  logic        flushed;

  always #5 CLK = ~CLK;

  dmem_write_buffer #(.DEPTH(DEPTH), .SLOW_DOWN_THRESH(2)) dut (
    .CLK                       (CLK),
    .nRST                      (nRST),
    .dmem_write_req_valid      (dmem_write_req_valid),
    .dmem_write_req_block_addr (dmem_write_req_block_addr),
    .dmem_write_req_data       (dmem_write_req_data),
    .dmem_write_req_blocked    (dmem_write_req_blocked),
    .dmem_write_req_slow_down  (dmem_write_req_slow_down),
    .dmem_read_req_valid       (dmem_read_req_valid),
    .dmem_read_req_block_addr  (dmem_read_req_block_addr),
    .dmem_read_req_blocked     (dmem_read_req_blocked),
    .dmem_read_resp_valid      (dmem_read_resp_valid),
    .dmem_read_resp_block_addr (dmem_read_resp_block_addr),
    .dmem_read_resp_data       (dmem_read_resp_data),
    .mc_read_req_valid         (mc_read_req_valid),
    .mc_read_req_block_addr    (mc_read_req_block_addr),
    .mc_read_resp_valid        (mc_read_resp_valid),
    .mc_read_resp_block_addr   (mc_read_resp_block_addr),
    .mc_read_resp_data         (mc_read_resp_data),
    .mc_write_req_valid        (mc_write_req_valid),
    .mc_write_req_block_addr   (mc_write_req_block_addr),
    .mc_write_req_data         (mc_write_req_data),
    .mc_write_req_ready        (mc_write_req_ready),
    .dcache_flushed            (dcache_flushed),
    .flushed                   (flushed)
  );

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } ent_t;

  ent_t        wbq[$];
  ent_t        lq[$];
  logic        m_rv;
  logic [12:0] m_ra;
  logic [63:0] m_rd;
  logic        m_fl;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    dmem_write_req_valid      = 1'b0;
    dmem_write_req_block_addr = '0;
    dmem_write_req_data       = '0;
    dmem_read_req_valid       = 1'b0;
    dmem_read_req_block_addr  = '0;
    mc_read_resp_valid        = 1'b0;
    mc_read_resp_block_addr   = '0;
    mc_read_resp_data         = '0;
    mc_write_req_ready        = 1'b0;
    dcache_flushed            = 1'b0;
  endtask

  // Asserted asynchronously; every output must be zero while reset is held.
  task automatic do_reset();
    set_idle();
    nRST = 1'b0;
    #1;
    check("rst_wr_blocked", 64'(dmem_write_req_blocked), 64'd0);
    check("rst_slow_down", 64'(dmem_write_req_slow_down), 64'd0);
    check("rst_rd_blocked", 64'(dmem_read_req_blocked), 64'd0);
    check("rst_resp_valid", 64'(dmem_read_resp_valid), 64'd0);
    check("rst_resp_addr", 64'(dmem_read_resp_block_addr), 64'd0);
    check("rst_resp_data", dmem_read_resp_data, 64'd0);
    check("rst_mc_rd_valid", 64'(mc_read_req_valid), 64'd0);
    check("rst_mc_wr_valid", 64'(mc_write_req_valid), 64'd0);
    check("rst_mc_wr_addr", 64'(mc_write_req_block_addr), 64'd0);
    check("rst_mc_wr_data", mc_write_req_data, 64'd0);
    check("rst_flushed", 64'(flushed), 64'd0);
    wbq.delete();
    lq.delete();
    m_rv = 1'b0;
    m_ra = '0;
    m_rd = '0;
    m_fl = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // One clock: compare outputs for the currently driven inputs, then advance the model.
  task automatic cycle();
    bit          w_acc;
    bit          r_acc;
    bit          hit;
    bit          drain;
    int          ci;
    logic [63:0] hd;
    ent_t        pend[$];
    ent_t        ne;
    hd  = '0;
    hit = 1'b0;
    @(negedge CLK);
    w_acc = dmem_write_req_valid && (wbq.size() < DEPTH);
    r_acc = dmem_read_req_valid && (lq.size() < 2);
    foreach (wbq[i]) begin
      if (wbq[i].addr == dmem_read_req_block_addr) begin
        hit = 1'b1;
        hd  = wbq[i].data;
      end
    end
    if (w_acc && (dmem_write_req_block_addr == dmem_read_req_block_addr)) begin
      hit = 1'b1;
      hd  = dmem_write_req_data;
    end

    check("wr_blocked", 64'(dmem_write_req_blocked), 64'(wbq.size() == DEPTH));
    check("slow_down", 64'(dmem_write_req_slow_down), 64'(wbq.size() >= 2));
    check("rd_blocked", 64'(dmem_read_req_blocked), 64'(lq.size() == 2));
    check("mc_wr_valid", 64'(mc_write_req_valid), 64'(wbq.size() > 0));
    if (wbq.size() > 0) begin
      check("mc_wr_addr", 64'(mc_write_req_block_addr), 64'(wbq[0].addr));
      check("mc_wr_data", mc_write_req_data, wbq[0].data);
    end
    check("mc_rd_valid", 64'(mc_read_req_valid), 64'(r_acc && !hit));
    if (r_acc && !hit) begin
      check("mc_rd_addr", 64'(mc_read_req_block_addr), 64'(dmem_read_req_block_addr));
    end
    check("resp_valid", 64'(dmem_read_resp_valid), 64'(m_rv));
    if (m_rv) begin
      check("resp_addr", 64'(dmem_read_resp_block_addr), 64'(m_ra));
      check("resp_data", dmem_read_resp_data, m_rd);
    end
    check("flushed", 64'(flushed), 64'(m_fl));

    if (dcache_flushed && (wbq.size() == 0) && (lq.size() == 0)) m_fl = 1'b1;

    drain = (wbq.size() > 0) && mc_write_req_ready;
    if (w_acc) begin
      ci = -1;
      for (int i = (drain ? 1 : 0); i < wbq.size(); i++) begin
        if (wbq[i].addr == dmem_write_req_block_addr) ci = i;
      end
      if (ci >= 0) begin
        wbq[ci].data = dmem_write_req_data;
      end else begin
        ne.addr = dmem_write_req_block_addr;
        ne.data = dmem_write_req_data;
        wbq.push_back(ne);
      end
    end
    if (drain) void'(wbq.pop_front());

    pend = lq;
    if (r_acc && hit) begin
      ne.addr = dmem_read_req_block_addr;
      ne.data = hd;
      pend.push_back(ne);
    end
    if (mc_read_resp_valid) begin
      m_rv = 1'b1;
      m_ra = mc_read_resp_block_addr;
      m_rd = mc_read_resp_data;
    end else if (pend.size() > 0) begin
      m_rv = 1'b1;
      m_ra = pend[0].addr;
      m_rd = pend[0].data;
      void'(pend.pop_front());
    end else begin
      m_rv = 1'b0;
    end
    lq = pend;

    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit w, input logic [12:0] wa, input logic [63:0] wd,
                       input bit r, input logic [12:0] ra, input bit rdy, input bit mcv);
    dmem_write_req_valid      = w;
    dmem_write_req_block_addr = wa;
    dmem_write_req_data       = wd;
    dmem_read_req_valid       = r;
    dmem_read_req_block_addr  = ra;
    mc_write_req_ready        = rdy;
    mc_read_resp_valid        = mcv;
    mc_read_resp_block_addr   = 13'($urandom);
    mc_read_resp_data         = {$urandom, $urandom};
    cycle();
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    nRST = 1'b1;
    set_idle();
    #2;
    do_reset();

    // single write, then one-cycle drain
    drive(1'b1, 13'h010, 64'h11111111_22222222, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 1);
    idle(1'b0, 1);

    // coalesce A then B into one entry
    drive(1'b1, 13'h010, 64'hAAAA0000_AAAA0001, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 13'h010, 64'hBBBB0000_BBBB0001, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // head draining in the same cycle: B becomes a separate entry
    drive(1'b1, 13'h010, 64'hAAAA0000_AAAA0001, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 13'h010, 64'hBBBB0000_BBBB0001, 1'b0, '0, 1'b1, 1'b0);
    idle(1'b1, 3);

    // fill to blocked, hold a fifth write across the freeing drain
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 13'(i), {32'(i), 32'hC0DE0000}, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 13'h005, 64'h55555555_55555555, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 13'h005, 64'h55555555_55555555, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 13'h005, 64'h55555555_55555555, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b1, 6);

    // local hit and forwarded miss
    drive(1'b1, 13'h020, 64'h0000DEAD_0000BEEF, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 13'h020, 1'b0, 1'b0);
    idle(1'b0, 1);
    drive(1'b0, '0, '0, 1'b1, 13'h021, 1'b0, 1'b0);
    idle(1'b0, 1);

    // controller responses take priority; local queue fills to blocked
    drive(1'b0, '0, '0, 1'b1, 13'h020, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 13'h020, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 13'h020, 1'b0, 1'b0);
    idle(1'b0, 3);

    // flush waits for the buffer to drain
    dcache_flushed = 1'b1;
    drive(1'b1, 13'h030, 64'h30303030_30303030, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 4);
    dcache_flushed = 1'b0;
    idle(1'b0, 2);

    // reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 13'(16'h40 + i), {$urandom, $urandom}, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #3;
    do_reset();

    // randomized traffic over a small address pool
    for (int n = 0; n < 1500; n++) begin
      dcache_flushed = (n > 1000) && ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 99) < 50, 13'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 99) < 40, 13'($urandom_range(0, 9)),
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15);
      if (n == 700) begin
        #3;
        do_reset();
      end
    end
    dcache_flushed = 1'b1;
    idle(1'b1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
